// File: rtl/spis_trans_engine.sv
// spis_trans_engine: SPI slave protocol engine.
// Oversamples the SPI pins in the clk domain, shifts tx FIFO bytes out on MISO
// and pushes every completed MOSI byte into the rx FIFO.
// Ports:
//   clk, rst                      system clock, async active-high reset
//   spi_sclk, spi_cs_n, spi_mosi  asynchronous pins from the master
//   spi_miso, spi_miso_oe         slave data out and pad output enable
//   r_enable, r_cpol, r_cpha      enable and SPI mode
//   r_msblsb                      0 = MSB first, 1 = LSB first
//   tx_fifo_re/rdata/empty        tx FIFO pop interface (rdata sampled while re=1)
//   rx_fifo_we/wdata/full         rx FIFO push interface
//   busy                          engine is not idle
//   int_status_*                  single-cycle event pulses
module spis_trans_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       r_enable,
  input  logic       r_cpol,
  input  logic       r_cpha,
  input  logic       r_msblsb,
  output logic       tx_fifo_re,
  input  logic [7:0] tx_fifo_rdata,
  input  logic       tx_fifo_empty,
  output logic       rx_fifo_we,
  output logic [7:0] rx_fifo_wdata,
  input  logic       rx_fifo_full,
  output logic       busy,
  output logic       int_status_tx_underflow,
  output logic       int_status_rx_overflow,
  output logic       int_status_cs_rise
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   cs_fall, cs_rise, do_load;
  logic [3:0]             bit_cnt;
  logic [7:0]             tx_shift, rx_shift, rx_next;

  // CS synchronizer resets to the deasserted level so that releasing reset
  // with CS_N high does not look like an end-of-frame edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
  assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == r_cpol);
  assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == r_cpol);
  assign sample_edge = r_cpha ? trail_edge : lead_edge;
  assign shift_edge  = r_cpha ? lead_edge : trail_edge;
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;

  // A byte is (re)loaded on frame start and on the first shift edge after
  // a full byte has been sampled.
  assign do_load = (state == LOAD) ||
                   ((state == SHIFT) && shift_edge && (bit_cnt == 4'd8));

  assign rx_next = r_msblsb ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};

  // MISO is a pure function of registers and is forced low when not driving.
  assign spi_miso = spi_miso_oe & (r_msblsb ? tx_shift[0] : tx_shift[7]);
  assign busy     = (state != IDLE);

  // Frame FSM. A popped tx byte is captured in the cycle its pop pulse is
  // high, so tx_fifo_re doubles as the capture strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      bit_cnt                 <= 4'd0;
      tx_shift                <= 8'h00;
      rx_shift                <= 8'h00;
      spi_miso_oe             <= 1'b0;
      tx_fifo_re              <= 1'b0;
      rx_fifo_we              <= 1'b0;
      rx_fifo_wdata           <= 8'h00;
      int_status_tx_underflow <= 1'b0;
      int_status_rx_overflow  <= 1'b0;
      int_status_cs_rise      <= 1'b0;
    end else begin
      tx_fifo_re              <= 1'b0;
      rx_fifo_we              <= 1'b0;
      int_status_tx_underflow <= 1'b0;
      int_status_rx_overflow  <= 1'b0;
      int_status_cs_rise      <= 1'b0;
      if (!r_enable) begin
        state       <= IDLE;
        spi_miso_oe <= 1'b0;
      end else if ((state != IDLE) && cs_rise) begin
        state              <= IDLE;
        spi_miso_oe        <= 1'b0;
        int_status_cs_rise <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state       <= LOAD;
              spi_miso_oe <= 1'b1;
            end
          end
          LOAD:    state <= SHIFT;
          SHIFT:   state <= SHIFT;
          default: state <= IDLE;
        endcase

        if (do_load) begin
          bit_cnt <= 4'd0;
          if (!tx_fifo_empty) begin
            tx_fifo_re <= 1'b1;
          end else begin
            tx_shift                <= 8'hFF;
            int_status_tx_underflow <= 1'b1;
          end
        end else if (tx_fifo_re) begin
          tx_shift <= tx_fifo_rdata;
        end else if ((state == SHIFT) && shift_edge && (bit_cnt != 4'd0)) begin
          tx_shift <= r_msblsb ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
        end

        if ((state == SHIFT) && sample_edge && (bit_cnt < 4'd8)) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (rx_fifo_full) begin
              int_status_rx_overflow <= 1'b1;
            end else begin
              rx_fifo_we    <= 1'b1;
              rx_fifo_wdata <= rx_next;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spis_trans_engine.sv
// tb_spis_trans_engine: scoreboard bench for spis_trans_engine.
// A behavioural SPI master drives frames; expected MISO and rx bytes are
// queued as stimulus is set up and consumed as the DUT produces them.
module tb_spis_trans_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic        r_enable = 1'b1, r_cpol = 1'b0, r_cpha = 1'b0, r_msblsb = 1'b0;
  logic        tx_fifo_re;
  logic [7:0]  tx_fifo_rdata = 8'h00;
  logic        tx_fifo_empty = 1'b1;
  logic        rx_fifo_we;
  logic [7:0]  rx_fifo_wdata;
  logic        rx_fifo_full = 1'b0;
  logic        busy;
  logic        int_status_tx_underflow, int_status_rx_overflow, int_status_cs_rise;
  logic [16:0] out_vec;

  int          errors = 0;
  int          checks = 0;
  int          re_cnt, we_cnt, uf_cnt, of_cnt, cs_cnt;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  miso_exp[$];
  logic [7:0]  got_byte;

  always #5 clk = ~clk;

  spis_trans_engine #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .r_enable(r_enable), .r_cpol(r_cpol), .r_cpha(r_cpha), .r_msblsb(r_msblsb),
    .tx_fifo_re(tx_fifo_re), .tx_fifo_rdata(tx_fifo_rdata), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_we(rx_fifo_we), .rx_fifo_wdata(rx_fifo_wdata), .rx_fifo_full(rx_fifo_full),
    .busy(busy),
    .int_status_tx_underflow(int_status_tx_underflow),
    .int_status_rx_overflow(int_status_rx_overflow),
    .int_status_cs_rise(int_status_cs_rise)
  );

  assign out_vec = {spi_miso, spi_miso_oe, tx_fifo_re, rx_fifo_we, rx_fifo_wdata, busy,
                    int_status_tx_underflow, int_status_rx_overflow, int_status_cs_rise};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First-word-fall-through tx FIFO model: head is presented, popped on re.
  always @(posedge clk) begin
    if (tx_fifo_re && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_fifo_rdata <= (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    tx_fifo_empty <= (tx_q.size() == 0);
  end

  // Output monitor: counts high cycles of every pulse and scores rx pushes.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_fifo_re) re_cnt++;
      if (int_status_tx_underflow) uf_cnt++;
      if (int_status_rx_overflow) of_cnt++;
      if (int_status_cs_rise) cs_cnt++;
      if (rx_fifo_we) begin
        we_cnt++;
        checkOutput("rx_q_nonempty", rx_exp.size() > 0, 1);
        if (rx_exp.size() > 0) checkOutput("rx_data", rx_fifo_wdata, rx_exp.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic getBit(input logic [15:0] d, input int n);
    logic [7:0] b;
    b = d[8*(n/8) +: 8];
    return r_msblsb ? b[n%8] : b[7-(n%8)];
  endfunction

  // Collects one MISO bit; on a completed byte scores MISO and queues rx.
  task automatic recordBit(input logic [15:0] d, input int n, input logic bitv);
    int i;
    i = n % 8;
    if (r_msblsb) got_byte[i] = bitv;
    else got_byte[7-i] = bitv;
    if (i == 7) begin
      checkOutput("miso_q_nonempty", miso_exp.size() > 0, 1);
      if (miso_exp.size() > 0)
        checkOutput($sformatf("miso_byte%0d", n/8), got_byte, miso_exp.pop_front());
      if (!rx_fifo_full) rx_exp.push_back(d[8*(n/8) +: 8]);
      got_byte = 8'h00;
    end
  endtask

  // SPI master: half period 8 clk, CS setup 8 clk, nbits bits of data.
  task automatic applyStimulus(input logic [15:0] d, input int nbits, input bit raise_cs);
    logic mb;
    got_byte = 8'h00;
    spi_sclk = r_cpol;
    if (!r_cpha) spi_mosi = getBit(d, 0);
    spi_cs_n = 1'b0;
    waitClk(8);
    for (int n = 0; n < nbits; n++) begin
      if (!r_cpha) begin
        mb = spi_miso;
        spi_sclk = ~r_cpol;
        recordBit(d, n, mb);
        waitClk(8);
        spi_sclk = r_cpol;
        if (n + 1 < nbits) spi_mosi = getBit(d, n + 1);
        waitClk(8);
      end else begin
        spi_sclk = ~r_cpol;
        spi_mosi = getBit(d, n);
        waitClk(8);
        mb = spi_miso;
        spi_sclk = r_cpol;
        recordBit(d, n, mb);
        waitClk(8);
      end
    end
    if (raise_cs) begin
      spi_cs_n = 1'b1;
      waitClk(8);
    end
  endtask

  task automatic startScenario(input logic cpol, input logic cpha, input logic lsb);
    r_cpol = cpol;
    r_cpha = cpha;
    r_msblsb = lsb;
    spi_sclk = cpol;
    waitClk(8);
    re_cnt = 0; we_cnt = 0; uf_cnt = 0; of_cnt = 0; cs_cnt = 0;
  endtask

  task automatic endScenario(input string tag, input int exp_re, input int exp_we,
                             input int exp_uf, input int exp_of, input int exp_cs);
    waitClk(10);
    checkOutput({tag, "_re_cycles"}, re_cnt, exp_re);
    checkOutput({tag, "_we_cycles"}, we_cnt, exp_we);
    if (exp_uf >= 0) checkOutput({tag, "_underflow_cycles"}, uf_cnt, exp_uf);
    checkOutput({tag, "_overflow_cycles"}, of_cnt, exp_of);
    checkOutput({tag, "_cs_rise_cycles"}, cs_cnt, exp_cs);
    checkOutput({tag, "_rx_left"}, rx_exp.size(), 0);
    checkOutput({tag, "_miso_left"}, miso_exp.size(), 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1;
    checkOutput("reset_outputs", out_vec, 0);
    waitClk(3);
    rst = 1'b0;
    waitClk(3);
    checkOutput("idle_outputs", out_vec, 0);

    // Mode 0, MSB first: 0xA5 out, 0x3C in. The trailing edge after the last
    // bit starts a reload from an empty FIFO, so underflow is not scored here.
    startScenario(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'hA5); miso_exp.push_back(8'hA5);
    applyStimulus(16'h003C, 8, 1'b1);
    endScenario("mode0", 1, 1, -1, 0, 1);

    // Mode 3, LSB first, two bytes.
    startScenario(1'b1, 1'b1, 1'b1);
    tx_q.push_back(8'h81); tx_q.push_back(8'h0F);
    miso_exp.push_back(8'h81); miso_exp.push_back(8'h0F);
    applyStimulus(16'hF055, 16, 1'b1);
    endScenario("mode3", 2, 2, 0, 0, 1);

    // Underflow: empty tx FIFO sends 0xFF without a pop.
    startScenario(1'b0, 1'b1, 1'b0);
    miso_exp.push_back(8'hFF);
    applyStimulus(16'h00A0, 8, 1'b1);
    endScenario("underflow", 0, 1, 1, 0, 1);

    // Overflow: full rx FIFO drops the byte.
    startScenario(1'b0, 1'b1, 1'b0);
    tx_q.push_back(8'h5A); miso_exp.push_back(8'h5A);
    rx_fifo_full = 1'b1;
    applyStimulus(16'h0012, 8, 1'b1);
    endScenario("overflow", 1, 0, 0, 1, 1);
    rx_fifo_full = 1'b0;

    // CS abort after 5 bits, then a clean frame.
    startScenario(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'h96);
    applyStimulus(16'h00C3, 5, 1'b1);
    checkOutput("abort_miso_oe", spi_miso_oe, 0);
    checkOutput("abort_miso", spi_miso, 0);
    endScenario("abort", 1, 0, 0, 0, 1);
    startScenario(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'h3B); miso_exp.push_back(8'h3B);
    applyStimulus(16'h007E, 8, 1'b1);
    endScenario("after_abort", 1, 1, -1, 0, 1);

    // Async reset after 3 bits, then a full mode 0 frame.
    startScenario(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'hA5);
    applyStimulus(16'h003C, 3, 1'b0);
    checkOutput("pre_reset_oe", spi_miso_oe, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("mid_frame_reset_outputs", out_vec, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tx_q.delete();
    waitClk(4);
    rst = 1'b0;
    startScenario(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'hA5); miso_exp.push_back(8'hA5);
    applyStimulus(16'h003C, 8, 1'b1);
    endScenario("post_reset", 1, 1, -1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
